// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage slice.
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        misaligned;
    } fetch_entry_t;

    typedef enum logic [1:0] {RUN, WAIT, DRAIN, HALT} fetch_state_e;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory request/response handshake.
interface fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master(output req, addr, input gnt, rvalid, rdata);
    modport slave(input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: synchronous FIFO of fetch entries; flush wins over push.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t dout,
    output logic [CW-1:0] count
);
    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr, rd;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && count != '0;
        do_push = push && !flush && (count != CW'(DEPTH) || do_pop);
    end

    assign dout = mem[rd];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr    <= '0;
            rd    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= wr + AW'(1);
            if (do_pop) rd <= rd + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, one-outstanding instruction fetch and fetch queue feeding decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched/perf_flushed counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        exception_pending,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    fetch_if.master     imem,
    output logic [31:0] pc2,
    output logic [31:0] instr2,
    output logic        valid2,
    output logic        instruction_addr_misaligned2
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_flushed
`endif
);
    localparam int CW = $clog2(FQ_DEPTH) + 1;

    fetch_state_e  state;
    logic [31:0]   pc, req_pc;
    logic          mis_pend;
    logic [CW-1:0] count;
    fetch_entry_t  head, push_data;
    logic          inflight, issue_ok, gnt_ok, mark, push, pop;

    always_comb begin
        inflight  = state == WAIT || state == DRAIN;
        issue_ok  = !rst && state == RUN && !exception_pending &&
                    (32'(count) + 32'(inflight) < 32'(FQ_DEPTH));
        mark      = issue_ok && mis_pend;
        gnt_ok    = issue_ok && !mis_pend && imem.gnt;
        push      = !redirect && (mark || (state == WAIT && imem.rvalid));
        pop       = valid2 && !stall && !redirect;
        push_data.pc         = mark ? pc : req_pc;
        push_data.instr      = mark ? NOP_INSTR : imem.rdata;
        push_data.misaligned = mark;
    end

    // A misaligned target takes the issue slot as a queue marker instead of a memory request.
    assign imem.req  = issue_ok && !mis_pend;
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            pc       <= RESET_PC;
            req_pc   <= '0;
            mis_pend <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            mis_pend <= |redirect_pc[1:0];
            state    <= ((inflight && !imem.rvalid) || gnt_ok) ? DRAIN : RUN;
        end else if (gnt_ok) begin
            pc     <= pc + 32'd4;
            req_pc <= pc;
            state  <= WAIT;
        end else if (mark) begin
            mis_pend <= 1'b0;
            state    <= HALT;
        end else if (inflight && imem.rvalid) begin
            state <= RUN;
        end
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .pop  (pop),
        .flush(redirect),
        .din  (push_data),
        .dout (head),
        .count(count)
    );

    always_comb begin
        valid2                       = count != '0;
        pc2                          = valid2 ? head.pc : 32'h0;
        instr2                       = valid2 ? head.instr : NOP_INSTR;
        instruction_addr_misaligned2 = valid2 && head.misaligned;
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched <= '0;
            perf_flushed <= '0;
        end else begin
            if (push && !mark) perf_fetched <= perf_fetched + 32'd1;
            if (redirect) perf_flushed <= perf_flushed + 32'(count) + 32'(state == WAIT || gnt_ok);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: randomized memory/redirect/stall stimulus against an expected fetch-stream model.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        exception_pending = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] pc2, instr2;
    logic        valid2, mis2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    fetch_if imem();

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0), .FQ_DEPTH(2)) dut (
        .clk                         (clk),
        .rst                         (rst),
        .stall                       (stall),
        .exception_pending           (exception_pending),
        .redirect                    (redirect),
        .redirect_pc                 (redirect_pc),
        .imem                        (imem),
        .pc2                         (pc2),
        .instr2                      (instr2),
        .valid2                      (valid2),
        .instruction_addr_misaligned2(mis2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched                (perf_fetched),
        .perf_flushed                (perf_flushed)
`endif
    );

    int n_checks = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        logic        pending = 1'b0;
        int          dly = 0;
        logic [31:0] paddr = '0, next_req = '0, exp_pc = '0, tgt;
        logic        mdl_mis = 1'b0, marker_done = 1'b0;
        logic        pv = 1'b0, ps = 1'b0, pr = 1'b0, pmis = 1'b0;
        logic [31:0] ppc = '0, pins = '0;
        logic        rv, consume, gnt_now;
        int          pops = 0;
        imem.gnt = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_valid2", valid2, 0);
        check("rst_pc2", pc2, 0);
        check("rst_instr2", instr2, NOP_INSTR);
        check("rst_mis2", mis2, 0);
        check("rst_req", imem.req, 0);
        rst = 1'b0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rv = pending && dly == 0;
            imem.rvalid = rv;
            imem.rdata = rv ? mem_word(paddr) : $urandom;
            imem.gnt = 1'b0;
            redirect = (cyc > 40) && ($urandom_range(0, 24) == 0);
            tgt = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
            if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFF0;
            if ($urandom_range(0, 3) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            redirect_pc = redirect ? tgt : $urandom;
            stall = (cyc % 97 < 8) || ($urandom_range(0, 4) == 0);
            exception_pending = (cyc % 331 < 20) && cyc > 300;
            #1;
            if (pr) check("flush_valid2", valid2, 0);
            if (ps && !pr && pv) begin
                check("hold_valid2", valid2, 1);
                check("hold_pc2", pc2, ppc);
                check("hold_instr2", instr2, pins);
                check("hold_mis2", mis2, pmis);
            end
            if (exception_pending) check("req_exc", imem.req, 0);
            if (pending) check("req_outstanding", imem.req, 0);
            if (mdl_mis) check("req_misaligned", imem.req, 0);
            if (imem.req) check("req_addr", imem.addr, next_req);
            consume = valid2 && !stall && !redirect;
            if (consume) begin
                pops++;
                if (marker_done) check("extra_pop", valid2, 0);
                else if (mdl_mis) begin
                    check("marker_pc2", pc2, exp_pc);
                    check("marker_instr2", instr2, NOP_INSTR);
                    check("marker_mis2", mis2, 1);
                    marker_done = 1'b1;
                end else begin
                    check("pop_pc2", pc2, exp_pc);
                    check("pop_instr2", instr2, mem_word(exp_pc));
                    check("pop_mis2", mis2, 0);
                    exp_pc = exp_pc + 32'd4;
                end
            end
            gnt_now = imem.req && !pending && ($urandom_range(0, 2) != 0);
            imem.gnt = gnt_now;
            if (rv) pending = 1'b0;
            else if (pending) dly--;
            if (gnt_now) begin
                pending = 1'b1;
                paddr = imem.addr;
                dly = $urandom_range(0, 2);
                next_req = next_req + 32'd4;
            end
            if (redirect) begin
                next_req = tgt;
                exp_pc = tgt;
                mdl_mis = |tgt[1:0];
                marker_done = 1'b0;
            end
            pv = valid2;
            ps = stall;
            pr = redirect;
            ppc = pc2;
            pins = instr2;
            pmis = mis2;
        end
        check("progress", {31'b0, pops > 300}, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
